riscv_pbus_master: RTL and testbench
====================================

RISCV_PBUS_MASTER -- requirements
Module: riscv_pbus_master

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter ACCESS_CYCLES, default 1, number of cycles enable is held; legal range 1..15.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  core requests a peripheral access.
REQ-006 SHALL have port req_ready  out  1  block accepts a request this cycle.
REQ-007 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  XLEN  byte address.
REQ-009 SHALL have port req_wdata  in  XLEN  store data.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  out  XLEN  load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  out  1  misaligned-access error, qualified by rsp_valid.
REQ-013 SHALL have ports sel, enable, write (out, 1 each), addr and wdata (out, XLEN each), and rdata (in, XLEN): peripheral bus to riscv_uart and siblings.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-015 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid & req_ready at a rising edge.
REQ-016 SHALL capture req_write, req_addr and req_wdata on acceptance; later changes on req_* SHALL NOT affect the transfer in flight.
REQ-017 SHALL go IDLE->SETUP on acceptance of an aligned request (req_addr[1:0] == 0).
REQ-018 SHALL, on acceptance of a misaligned request, stay in IDLE, start no bus activity, and assert rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle.
REQ-019 SHALL drive sel=1, enable=0 in SETUP, with addr, wdata and write valid from the registered request; the FSM SHALL then move to ACCESS.
REQ-020 SHALL drive sel=1, enable=1 in ACCESS for exactly ACCESS_CYCLES consecutive cycles, counted by an internal down-counter.
REQ-021 SHALL hold addr, wdata and write stable from SETUP through the last ACCESS cycle.
REQ-022 SHALL, on the last ACCESS cycle: sample rdata into rsp_rdata for loads (0 for stores), go to IDLE, and assert rsp_valid=1, rsp_err=0 in the following cycle.
REQ-023 SHALL drive sel=0 and enable=0 in IDLE; addr, wdata and write keep their last values.
REQ-024 SHALL assert rsp_valid for exactly one cycle per accepted request.
REQ-025 SHALL keep rsp_rdata stable until the next rsp_valid.
REQ-026 SHALL give a latency of acceptance edge N -> SETUP in cycle N+1 -> ACCESS in cycles N+2..N+1+ACCESS_CYCLES -> rsp_valid in cycle N+2+ACCESS_CYCLES.
REQ-027 SHALL allow back-to-back transfers: req_ready=1 in the rsp_valid cycle, so a new request accepted there enters SETUP on the next cycle.
REQ-028 SHALL register all outputs; there SHALL be no combinational path from req_* or rdata to any output.

Reset
REQ-029 SHALL, when rstn=0 at a rising edge, set the FSM to IDLE and the counter to 0, and set sel, enable, write, rsp_valid and rsp_err to 0 and addr, wdata and rsp_rdata to 0.
REQ-030 SHALL, if reset hits during SETUP or ACCESS, abandon the transfer, produce no rsp_valid for it, and accept no request while rstn=0 (req_ready=0).

Verification
REQ-031 Store (ACCESS_CYCLES=1): req write, addr 0x004, wdata 0xA5 accepted at edge N -> cycle N+1 sel=1/enable=0; N+2 sel=1/enable=1, addr 0x004, wdata 0xA5, write=1; N+3 rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-032 Load: req read, addr 0x008, peripheral rdata 0x0000_005A -> rsp_valid with rsp_rdata 0x5A, write=0 throughout.
REQ-033 Misaligned: req addr 0x006 -> sel stays 0 for all cycles; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-034 Back-to-back: req_valid held high with two stores (0x004/0x11, 0x004/0x22) -> second SETUP immediately after first rsp_valid cycle, two rsp_valid pulses 3 cycles apart.
REQ-035 ACCESS_CYCLES=3: one load -> enable=1 for exactly 3 cycles, rsp_valid 5 cycles after acceptance, rdata sampled in 3rd ACCESS cycle.
REQ-036 Reset mid-ACCESS: rstn=0 during enable=1 -> next edge sel=enable=0, FSM IDLE, no rsp_valid; after rstn=1 a new store completes normally.

Source files
------------

// File: rtl/riscv_pbus_master.sv
// Peripheral bus master for the RISC-V core: turns one core load/store request
// into a SETUP/ACCESS bus transfer and returns a single-cycle response.
module riscv_pbus_master #(
  parameter int XLEN          = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            sel,
  output logic            enable,
  output logic            write,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter holds the number of ACCESS cycles still to come after the current one.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       accept;
  logic       aligned;
  logic       last_access;

  assign accept      = req_valid && (state == IDLE);
  assign aligned     = (req_addr[1:0] == 2'b00);
  assign last_access = (state == ACCESS) && (cnt == 4'd0);

  // Gated by rstn so no request can be taken while reset is held.
  assign req_ready = (state == IDLE) && rstn;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept && aligned) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sel       <= 1'b0;
      enable    <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      // Bus strobes follow the state being entered so they line up with it.
      sel    <= (state_next != IDLE);
      enable <= (state_next == ACCESS);
      if (accept && aligned) begin
        write <= req_write;
        addr  <= req_addr;
        wdata <= req_wdata;
      end
      rsp_valid <= last_access || (accept && !aligned);
      rsp_err   <= accept && !aligned;
      if (last_access) begin
        rsp_rdata <= write ? '0 : rdata;
      end else if (accept && !aligned) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_pbus_master.sv
// Bench for riscv_pbus_master: two instances (ACCESS_CYCLES 1 and 3) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_riscv_pbus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  req_valid, req_write;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata[2];
  logic [31:0] rdata    [2];
  logic [1:0]  req_ready_w, rsp_valid_w, rsp_err_w, sel_w, en_w, write_w;
  logic [31:0] rsp_rdata_w[2];
  logic [31:0] addr_w     [2];
  logic [31:0] wdata_w    [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  riscv_pbus_master #(.XLEN(32), .ACCESS_CYCLES(1)) u_ac1 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[0]), .req_ready(req_ready_w[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid_w[0]), .rsp_rdata(rsp_rdata_w[0]), .rsp_err(rsp_err_w[0]),
    .sel(sel_w[0]), .enable(en_w[0]), .write(write_w[0]),
    .addr(addr_w[0]), .wdata(wdata_w[0]), .rdata(rdata[0])
  );

  riscv_pbus_master #(.XLEN(32), .ACCESS_CYCLES(3)) u_ac3 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid[1]), .req_ready(req_ready_w[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid_w[1]), .rsp_rdata(rsp_rdata_w[1]), .rsp_err(rsp_err_w[1]),
    .sel(sel_w[1]), .enable(en_w[1]), .write(write_w[1]),
    .addr(addr_w[1]), .wdata(wdata_w[1]), .rdata(rdata[1])
  );

  // Model: remembers the edge of the last aligned acceptance and of the last
  // misaligned acceptance; every expected output is a window around those edges.
  int          ac_tab[2] = '{1, 3};
  int          acc_a[2];
  int          mis_m[2];
  int          ready_from[2];
  bit          pend_wr[2];
  logic        e_write[2];
  logic [31:0] e_addr[2];
  logic [31:0] e_wdata[2];
  logic [31:0] e_rdata[2];

  task automatic cmp(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h, want %h", nm, inst, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_a[i] = -1000; mis_m[i] = -1000; ready_from[i] = 0; pend_wr[i] = 1'b0;
      e_write[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rstn) begin
          acc_a[i] = -1000; mis_m[i] = -1000; ready_from[i] = cyc + 1;
          e_write[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
        end else begin
          if (cyc == acc_a[i] + 1 + ac_tab[i]) begin
            e_rdata[i] = pend_wr[i] ? 32'd0 : rdata[i];
          end
          if (req_valid[i] && cyc >= ready_from[i]) begin
            if (req_addr[i][1:0] == 2'b00) begin
              acc_a[i]      = cyc;
              ready_from[i] = cyc + 2 + ac_tab[i];
              pend_wr[i]    = req_write[i];
              e_write[i]    = req_write[i];
              e_addr[i]     = req_addr[i];
              e_wdata[i]    = req_wdata[i];
            end else begin
              mis_m[i]   = cyc;
              e_rdata[i] = '0;
            end
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    int   a;
    int   c;
    int   ac;
    logic x_sel, x_en, x_rv, x_err, x_rdy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          a = acc_a[i]; c = cyc; ac = ac_tab[i];
          x_sel = (c >= a + 1) && (c <= a + 1 + ac);
          x_en  = (c >= a + 2) && (c <= a + 1 + ac);
          x_err = (c == mis_m[i] + 1);
          x_rv  = (c == a + 2 + ac) || x_err;
          x_rdy = rstn && (c >= ready_from[i]);
          cmp("sel", i, 32'(sel_w[i]), 32'(x_sel));
          cmp("enable", i, 32'(en_w[i]), 32'(x_en));
          cmp("rsp_valid", i, 32'(rsp_valid_w[i]), 32'(x_rv));
          if (x_rv) cmp("rsp_err", i, 32'(rsp_err_w[i]), 32'(x_err));
          cmp("req_ready", i, 32'(req_ready_w[i]), 32'(x_rdy));
          cmp("write", i, 32'(write_w[i]), 32'(e_write[i]));
          cmp("addr", i, addr_w[i], e_addr[i]);
          cmp("wdata", i, wdata_w[i], e_wdata[i]);
          cmp("rsp_rdata", i, rsp_rdata_w[i], e_rdata[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge, then scrambles req_* to prove capture.
  task automatic issue(input int i, input logic wr, input logic [31:0] ad, input logic [31:0] wd);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = ad; req_wdata[i] = wd;
    tick();
    req_valid[i] = 1'b0; req_write[i] = ~wr;
    req_addr[i] = 32'hFFFF_FFF0 ^ ad; req_wdata[i] = ~wd;
  endtask

  typedef struct { logic wr; logic [31:0] ad; logic [31:0] wd; logic [31:0] rd; } vec_t;
  vec_t vecs[4] = '{
    '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0},
    '{1'b0, 32'h0000_0104, 32'h0,         32'h1234_5678},
    '{1'b0, 32'h0000_0103, 32'h0,         32'h0000_0055},
    '{1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 32'h0}
  };

  initial begin
    rstn = 1'b0; req_valid = '0; req_write = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; rdata[i] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmp("rst_sel", i, 32'(sel_w[i]), 32'd0);
      cmp("rst_enable", i, 32'(en_w[i]), 32'd0);
      cmp("rst_rsp_valid", i, 32'(rsp_valid_w[i]), 32'd0);
      cmp("rst_rsp_err", i, 32'(rsp_err_w[i]), 32'd0);
      cmp("rst_addr", i, addr_w[i], 32'd0);
      cmp("rst_rsp_rdata", i, rsp_rdata_w[i], 32'd0);
      cmp("rst_req_ready", i, 32'(req_ready_w[i]), 32'd0);
    end
    tick();
    rstn = 1'b1;
    tick();

    // Store, ACCESS_CYCLES=1
    issue(0, 1'b1, 32'h004, 32'hA5);
    @(negedge clk); cmp("st_setup_sel", 0, 32'(sel_w[0]), 32'd1);
    cmp("st_setup_en", 0, 32'(en_w[0]), 32'd0);
    tick();
    @(negedge clk); cmp("st_acc_en", 0, 32'(en_w[0]), 32'd1);
    cmp("st_acc_addr", 0, addr_w[0], 32'h004);
    cmp("st_acc_wdata", 0, wdata_w[0], 32'hA5);
    cmp("st_acc_write", 0, 32'(write_w[0]), 32'd1);
    tick();
    @(negedge clk); cmp("st_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'd1);
    cmp("st_rsp_err", 0, 32'(rsp_err_w[0]), 32'd0);
    cmp("st_rsp_rdata", 0, rsp_rdata_w[0], 32'd0);
    tick();

    // Load
    rdata[0] = 32'h0000_005A;
    issue(0, 1'b0, 32'h008, 32'h0);
    @(negedge clk); cmp("ld_write", 0, 32'(write_w[0]), 32'd0);
    tick(); tick();
    @(negedge clk); cmp("ld_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'd1);
    cmp("ld_rsp_rdata", 0, rsp_rdata_w[0], 32'h5A);
    tick();

    // Misaligned
    issue(0, 1'b0, 32'h006, 32'h0);
    @(negedge clk); cmp("mis_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'd1);
    cmp("mis_rsp_err", 0, 32'(rsp_err_w[0]), 32'd1);
    cmp("mis_rsp_rdata", 0, rsp_rdata_w[0], 32'd0);
    cmp("mis_sel", 0, 32'(sel_w[0]), 32'd0);
    tick();

    // Back-to-back stores with req_valid held
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h004; req_wdata[0] = 32'h11;
    tick();
    req_wdata[0] = 32'h22;
    tick(); tick();
    @(negedge clk); cmp("b2b_rsp1", 0, 32'(rsp_valid_w[0]), 32'd1);
    cmp("b2b_wdata1", 0, wdata_w[0], 32'h11);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk); cmp("b2b_setup2_sel", 0, 32'(sel_w[0]), 32'd1);
    cmp("b2b_setup2_en", 0, 32'(en_w[0]), 32'd0);
    cmp("b2b_wdata2", 0, wdata_w[0], 32'h22);
    tick(); tick();
    @(negedge clk); cmp("b2b_rsp2", 0, 32'(rsp_valid_w[0]), 32'd1);
    tick();

    // Reset mid-ACCESS, then a normal store
    issue(0, 1'b1, 32'h010, 32'h77);
    tick();
    rstn = 1'b0;
    @(negedge clk); cmp("rst_mid_en", 0, 32'(en_w[0]), 32'd1);
    tick();
    @(negedge clk); cmp("rst_mid_sel", 0, 32'(sel_w[0]), 32'd0);
    cmp("rst_mid_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'd0);
    cmp("rst_mid_ready", 0, 32'(req_ready_w[0]), 32'd0);
    rstn = 1'b1;
    tick();
    issue(0, 1'b1, 32'h020, 32'h99);
    tick(); tick();
    @(negedge clk); cmp("post_rst_rsp", 0, 32'(rsp_valid_w[0]), 32'd1);
    cmp("post_rst_addr", 0, addr_w[0], 32'h020);
    tick();

    // ACCESS_CYCLES=3 load with rdata changing every cycle
    rdata[1] = 32'hA0;
    issue(1, 1'b0, 32'h00C, 32'h0);
    rdata[1] = 32'hA1;
    @(negedge clk); cmp("ac3_setup_en", 1, 32'(en_w[1]), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      rdata[1] = 32'hA0 + 32'(k);
      @(negedge clk); cmp("ac3_acc_en", 1, 32'(en_w[1]), 32'd1);
    end
    tick();
    rdata[1] = 32'hA5;
    @(negedge clk); cmp("ac3_rsp_valid", 1, 32'(rsp_valid_w[1]), 32'd1);
    cmp("ac3_rsp_en", 1, 32'(en_w[1]), 32'd0);
    cmp("ac3_rsp_rdata", 1, rsp_rdata_w[1], 32'hA4);
    tick();

    // Table of mixed transfers on both instances, model-checked
    for (int i = 0; i < 2; i++) begin
      foreach (vecs[v]) begin
        rdata[i] = vecs[v].rd;
        issue(i, vecs[v].wr, vecs[v].ad, vecs[v].wd);
        repeat (ac_tab[i] + 3) tick();
      end
    end

    // Held req_valid on the slow instance with changing address and rdata
    req_valid[1] = 1'b1; req_write[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      req_addr[1] = 32'h40 + 32'(k);
      rdata[1]    = 32'h5000 + 32'(k);
      tick();
    end
    req_valid[1] = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
